// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter merging ALU and memory results onto one register-file port
module wb_arbiter #(
    parameter int REG_ADDR = 5,
    parameter int REG_SIZE = 32,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [REG_ADDR-1:0] alu_wreg,
    input  logic [REG_SIZE-1:0] alu_wdata,
    input  logic                mem_valid,
    input  logic [REG_ADDR-1:0] mem_wreg,
    input  logic [REG_SIZE-1:0] mem_wdata,
    output logic                mem_ready,
    output logic                regwrite,
    output logic [REG_ADDR-1:0] wreg,
    output logic [REG_SIZE-1:0] wdata,
    input  logic [REG_ADDR-1:0] chk_reg,
    output logic                chk_hit,
    output logic                busy
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]         count_q, count_d;
    logic [REG_ADDR-1:0] fifo_wreg_q  [DEPTH];
    logic [REG_SIZE-1:0] fifo_wdata_q [DEPTH];

    logic                regwrite_q, regwrite_d;
    logic [REG_ADDR-1:0] wreg_q, wreg_d;
    logic [REG_SIZE-1:0] wdata_q, wdata_d;

    logic alu_v, full, empty, mem_xfer, mem_keep, pop, push, bypass;

    // x0 writes are filtered here so neither path ever targets register 0
    always_comb begin
        alu_v     = alu_valid && (alu_wreg != '0);
        full      = (count_q == (PW+1)'(DEPTH));
        empty     = (count_q == '0);
        mem_ready = !full && !reset;
        mem_xfer  = mem_valid && mem_ready;
        mem_keep  = mem_xfer && (mem_wreg != '0);
        pop       = !alu_v && !empty;
        bypass    = !alu_v && empty && mem_keep;
        push      = mem_keep && !bypass;
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (alu_v) begin
            regwrite_d = 1'b1;
            wreg_d     = alu_wreg;
            wdata_d    = alu_wdata;
        end else if (pop) begin
            regwrite_d = 1'b1;
            wreg_d     = fifo_wreg_q[rd_ptr_q];
            wdata_d    = fifo_wdata_q[rd_ptr_q];
        end else if (bypass) begin
            regwrite_d = 1'b1;
            wreg_d     = mem_wreg;
            wdata_d    = mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Entry storage needs no reset: validity comes from the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wreg_q[wr_ptr_q]  <= mem_wreg;
            fifo_wdata_q[wr_ptr_q] <= mem_wdata;
        end
    end

    always_comb begin : hazard
        logic [PW-1:0] off;
        chk_hit = 1'b0;
        off     = '0;
        if (chk_reg != '0) begin
            if (regwrite_q && (wreg_q == chk_reg)) begin
                chk_hit = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                off = PW'(i) - rd_ptr_q;
                if (({1'b0, off} < count_q) && (fifo_wreg_q[i] == chk_reg)) begin
                    chk_hit = 1'b1;
                end
            end
        end
    end

    assign regwrite = regwrite_q;
    assign wreg     = wreg_q;
    assign wdata    = wdata_q;
    assign busy     = !empty;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that merges two result sources, the single-cycle ALU pipe and the variable-latency memory/multiply unit, onto the register file's single write port. ALU results always win and are never stalled. Memory results are accepted by valid/ready handshake and queued in a small FIFO when the port is taken. The block sits directly upstream of the register file and drives its `regwrite`/`wreg`/`wdata` inputs from registers.

## Interface
- `REG_ADDR`, default 5: register index width.
- `REG_SIZE`, default 32: data width.
- `DEPTH`, default 4: memory-result FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; always consumed.
- `alu_wreg`  in  REG_ADDR  ALU destination register.
- `alu_wdata`  in  REG_SIZE  ALU result.
- `mem_valid`  in  1  memory-unit result offered.
- `mem_wreg`  in  REG_ADDR  memory destination register.
- `mem_wdata`  in  REG_SIZE  memory result.
- `mem_ready`  out  1  arbiter can accept a memory result this cycle.
- `regwrite`  out  1  registered write enable to the register file.
- `wreg`  out  REG_ADDR  registered write index.
- `wdata`  out  REG_SIZE  registered write data.
- `chk_reg`  in  REG_ADDR  register index queried by the hazard unit.
- `chk_hit`  out  1  `chk_reg` has a write pending in the FIFO or in the output register.
- `busy`  out  1  FIFO non-empty.

## Operation
- Reset is one clock and asynchronous, active-high; the polarity and synchronicity are fixed.
- A memory transfer occurs when `mem_valid && mem_ready`.
- `mem_ready = !full && !reset`. It does not account for a same-cycle pop, so it is 0 whenever the FIFO is full.
- Filtering: an ALU result with `alu_wreg == 0` is treated as `alu_valid = 0`. A memory transfer with `mem_wreg == 0` is accepted (handshake completes) and then discarded, neither pushed nor forwarded.
- Output selection each cycle, in priority order:
  1. Valid ALU result: load it into the output register.
  2. Otherwise, FIFO non-empty: pop the head into the output register.
  3. Otherwise, accepted memory transfer: bypass it straight into the output register, with no push.
  4. Otherwise: `regwrite <= 0`; `wreg`/`wdata` hold their values.
- Push rule: an accepted, non-x0 memory transfer is pushed unless case 3 applied. This covers both the "ALU wins" case and the "FIFO draining" case.
- A push and a pop in the same cycle are both legal. Count is unchanged and FIFO order is preserved, so memory results leave in acceptance order.
- Pointers: read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. Count is `log2(DEPTH)+1` bits; `full = (count == DEPTH)`, `empty = (count == 0)`.
- `chk_hit` is combinational. It is 1 iff `chk_reg != 0` and either it equals the `wreg` of a valid FIFO entry, or `regwrite && wreg == chk_reg`.
- Ordering between ALU and memory writes to the same register is upstream's responsibility; the hazard unit uses `chk_hit` to stall.

## Timing
- Reset values: `regwrite = 0`, `wreg = 0`, `wdata = 0`, FIFO empty, `busy = 0`, `mem_ready = 0` while `reset` is high. All take effect immediately, without waiting for a clock edge.
- After reset deasserts, `mem_ready = 1` in the same cycle.
- ALU latency: 1 cycle, `alu_valid` at edge N gives `regwrite` high after edge N+1.
- Memory latency: 1 cycle on bypass. When queued, 1 cycle plus the number of cycles the FIFO head waits behind ALU writes and older entries.
- Output throughput: 1 write per cycle. The FIFO drains at 1 entry per cycle when no ALU result is present.
- Reset asserted mid-operation discards all queued entries; nothing is written after reset.
- `busy` and `full` reflect the registered count. `mem_ready` and `chk_hit` are combinational from registered state and inputs.

## Test plan
- Reset and idle: assert `reset` asynchronously between edges. Outputs clear immediately, `mem_ready = 0`. Release reset: `mem_ready = 1`, `regwrite = 0`.
- ALU only: `alu_valid`, `wreg = 3`, data `0xDEADBEEF`. Next cycle `regwrite = 1`, `wreg = 3`, `wdata = 0xDEADBEEF`. An ALU result with `wreg = 0` gives `regwrite = 0`.
- Bypass and conflict:
  - Memory alone with `wreg = 7`, data `0x11`: written the next cycle, `busy` stays 0.
  - Same cycle as ALU `wreg = 2`: the r2 write comes first, then r7 one cycle later, and `busy` is 1 for one cycle.
- Fill and back-pressure: hold `alu_valid` high and offer 5 memory results with `DEPTH = 4`.
  - After 4 transfers, `mem_ready = 0` and the 5th is held.
  - Drop `alu_valid`: entries drain in acceptance order, one per cycle, and `mem_ready` returns to 1 after the first pop.
- Pointer wrap: stream 10 memory results while an ALU result arrives every other cycle. All 10 are written exactly once, in order, and the count never exceeds 4.
- Hazard query: queue `wreg = 9` behind ALU traffic, `chk_reg = 9`.
  - `chk_hit = 1` until the cycle after the r9 write leaves the output register, then 0.
  - `chk_reg = 0` gives `chk_hit = 0` always.
